// File: rtl/y_ctrl_pkg.sv
// y_ctrl_pkg: shared types and encodings for the y-series multi-cycle controller.
//   state_t  - controller FSM states
//   iclass_t - instruction class produced by the decoder
//   OP_*/F_* - MIPS opcode and R-type funct encodings
//   ALU_*    - alu_op encodings driven to yEX
package y_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        CL_R,
        CL_ADDI,
        CL_LW,
        CL_SW,
        CL_BEQ,
        CL_J,
        CL_BAD
    } iclass_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2a;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/y_ctrl_decode.sv
// y_ctrl_decode: combinational instruction decoder for y_mc_ctrl.
// Optional macro Y_CTRL_SLT_EN: when defined, R-type slt is legal.
// Ports:
//   ir      in  32  latched instruction register
//   cls     out     instruction class (CL_BAD when undecodable)
//   reg_dst out  1  write destination is rd (R-type)
//   alu_src out  1  ALU B operand is the immediate
//   mem2reg out  1  writeback data comes from memory (lw)
//   alu_op  out  3  ALU operation
//   legal   out  1  instruction is supported
module y_ctrl_decode
    import y_ctrl_pkg::*;
(
    input  logic [31:0] ir,
    output iclass_t     cls,
    output logic        reg_dst,
    output logic        alu_src,
    output logic        mem2reg,
    output logic [2:0]  alu_op,
    output logic        legal
);

    always_comb begin
        cls     = CL_BAD;
        reg_dst = 1'b0;
        alu_src = 1'b0;
        mem2reg = 1'b0;
        alu_op  = ALU_ADD;
        legal   = 1'b0;
        case (ir[31:26])
            OP_RTYPE: begin
                reg_dst = 1'b1;
                case (ir[5:0])
                    F_ADD: begin
                        cls    = CL_R;
                        alu_op = ALU_ADD;
                        legal  = 1'b1;
                    end
                    F_OR: begin
                        cls    = CL_R;
                        alu_op = ALU_OR;
                        legal  = 1'b1;
                    end
`ifdef Y_CTRL_SLT_EN
                    F_SLT: begin
                        cls    = CL_R;
                        alu_op = ALU_SLT;
                        legal  = 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
            OP_ADDI: begin
                cls     = CL_ADDI;
                alu_src = 1'b1;
                legal   = 1'b1;
            end
            OP_LW: begin
                cls     = CL_LW;
                alu_src = 1'b1;
                mem2reg = 1'b1;
                legal   = 1'b1;
            end
            OP_SW: begin
                cls     = CL_SW;
                alu_src = 1'b1;
                legal   = 1'b1;
            end
            OP_BEQ: begin
                cls    = CL_BEQ;
                alu_op = ALU_SUB;
                legal  = 1'b1;
            end
            OP_J: begin
                cls   = CL_J;
                legal = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/y_mc_ctrl.sv
// y_mc_ctrl: multi-cycle controller and PC unit for the y-series MIPS datapath.
// Optional macro Y_CTRL_SLT_EN (see y_ctrl_decode) enables R-type slt.
// Ports:
//   clk, rst_n           clock (rising edge), synchronous active-low reset
//   ins                  instruction word from instruction memory
//   imm                  sign-extended immediate from yID
//   zero                 ALU zero flag from yEX
//   mem_ready            memory access completes this cycle
//   fetch_req, ir_write  fetch request at pc, IR capture pulse
//   reg_dst, reg_write, alu_src, mem_read, mem_write, mem2reg, alu_op
//                        datapath controls
//   pc                   program counter
//   halted, illegal      FSM in HALT, halt caused by undecodable instruction
//   insn_count           retired-instruction counter (saturating)
module y_mc_ctrl
    import y_ctrl_pkg::*;
#(
    parameter int unsigned PC_W      = 32,
    parameter int unsigned PC_RESET  = 128,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned MAX_INSNS = 43
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      ins,
    input  logic [31:0]      imm,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             fetch_req,
    output logic [PC_W-1:0]  pc,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem2reg,
    output logic [2:0]       alu_op,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] insn_count
);

    state_t      state;
    logic [31:0] ir;
    iclass_t     cls;
    logic        legal;

    // Mux selects come straight from the decoded IR, which is stable from
    // DECODE through WB.
    y_ctrl_decode u_decode (
        .ir      (ir),
        .cls     (cls),
        .reg_dst (reg_dst),
        .alu_src (alu_src),
        .mem2reg (mem2reg),
        .alu_op  (alu_op),
        .legal   (legal)
    );

    logic [PC_W-1:0]  pc_p4, pc_br, pc_j;
    logic [31:0]      pc_p4_w, j_w;
    logic [CNT_W-1:0] cnt_inc;
    state_t           retire_state;

    always_comb begin
        pc_p4   = pc + PC_W'(4);
        pc_br   = pc_p4 + (imm[PC_W-1:0] << 2);
        pc_p4_w = 32'(pc_p4);
        j_w     = (pc_p4_w & 32'hF000_0000) | {4'b0000, ir[25:0], 2'b00};
        pc_j    = j_w[PC_W-1:0];
        cnt_inc = (insn_count == '1) ? insn_count : insn_count + 1'b1;
        retire_state = ((MAX_INSNS != 0) && (cnt_inc == CNT_W'(MAX_INSNS)))
                       ? ST_HALT : ST_FETCH;
    end

    // Strobes are decoded from the state register; qualifying with rst_n
    // keeps them low for the whole time reset is held, not just after the
    // first reset edge.
    always_comb begin
        fetch_req = rst_n && (state == ST_FETCH);
        ir_write  = fetch_req && mem_ready;
        mem_read  = rst_n && (state == ST_MEM) && (cls == CL_LW);
        mem_write = rst_n && (state == ST_MEM) && (cls == CL_SW);
        reg_write = rst_n && (state == ST_WB);
        halted    = (state == ST_HALT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_FETCH;
            pc         <= PC_W'(PC_RESET);
            ir         <= '0;
            insn_count <= '0;
            illegal    <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (mem_ready) begin
                        ir    <= ins;
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (!legal) begin
                        illegal <= 1'b1;
                        state   <= ST_HALT;
                    end else if (cls == CL_J) begin
                        pc         <= pc_j;
                        insn_count <= cnt_inc;
                        state      <= retire_state;
                    end else begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (cls)
                        CL_BEQ: begin
                            pc         <= zero ? pc_br : pc_p4;
                            insn_count <= cnt_inc;
                            state      <= retire_state;
                        end
                        CL_LW, CL_SW: state <= ST_MEM;
                        default:      state <= ST_WB;
                    endcase
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        if (cls == CL_SW) begin
                            pc         <= pc_p4;
                            insn_count <= cnt_inc;
                            state      <= retire_state;
                        end else begin
                            state <= ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    pc         <= pc_p4;
                    insn_count <= cnt_inc;
                    state      <= retire_state;
                end
                ST_HALT: ;
                default: state <= ST_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_y_mc_ctrl.sv
// tb_y_mc_ctrl: directed self-checking bench for y_mc_ctrl.
// A second instance with MAX_INSNS=3 shares the stimulus to cover the
// retire budget. Expectations for slt follow macro Y_CTRL_SLT_EN.
module tb_y_mc_ctrl;

    localparam logic [31:0] I_ADD  = 32'h0109_5020;
    localparam logic [31:0] I_BEQ  = 32'h1109_FFFE;
    localparam logic [31:0] I_LW   = 32'h8D09_0004;
    localparam logic [31:0] I_SW   = 32'hAD09_0004;
    localparam logic [31:0] I_J200 = 32'h0800_0032;
    localparam logic [31:0] I_J80  = 32'h0800_0020;
    localparam logic [31:0] I_BAD  = 32'hFC00_0000;
    localparam logic [31:0] I_SLT  = 32'h0109_502A;

    logic        clk = 1'b0;
    logic        rst_n, zero, mem_ready;
    logic [31:0] ins, imm;

    logic        fetch_req, ir_write, reg_dst, reg_write, alu_src;
    logic        mem_read, mem_write, mem2reg, halted, illegal;
    logic [31:0] pc;
    logic [2:0]  alu_op;
    logic [15:0] insn_count;

    logic        b_fetch_req, b_ir_write, b_reg_dst, b_reg_write, b_alu_src;
    logic        b_mem_read, b_mem_write, b_mem2reg, b_halted, b_illegal;
    logic [31:0] b_pc;
    logic [2:0]  b_alu_op;
    logic [15:0] b_insn_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    y_mc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ins(ins), .imm(imm), .zero(zero),
        .mem_ready(mem_ready), .fetch_req(fetch_req), .pc(pc),
        .ir_write(ir_write), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src(alu_src), .mem_read(mem_read), .mem_write(mem_write),
        .mem2reg(mem2reg), .alu_op(alu_op), .halted(halted),
        .illegal(illegal), .insn_count(insn_count)
    );

    y_mc_ctrl #(.MAX_INSNS(3)) dut_budget (
        .clk(clk), .rst_n(rst_n), .ins(ins), .imm(imm), .zero(zero),
        .mem_ready(mem_ready), .fetch_req(b_fetch_req), .pc(b_pc),
        .ir_write(b_ir_write), .reg_dst(b_reg_dst), .reg_write(b_reg_write),
        .alu_src(b_alu_src), .mem_read(b_mem_read), .mem_write(b_mem_write),
        .mem2reg(b_mem2reg), .alu_op(b_alu_op), .halted(b_halted),
        .illegal(b_illegal), .insn_count(b_insn_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from a FETCH cycle until the next FETCH or HALT.
    task automatic run_insn(input logic [31:0] i_ins, input int mem_waits,
                            output int cycles, output int rd_cyc, output int wr_cyc,
                            output int rw_cyc, output logic m2r);
        int left;
        left   = mem_waits;
        cycles = 0;
        rd_cyc = 0;
        wr_cyc = 0;
        rw_cyc = 0;
        m2r    = 1'b0;
        ins    = i_ins;
        do begin
            if (mem_read || mem_write) begin
                if (left > 0) begin
                    mem_ready = 1'b0;
                    left--;
                end else begin
                    mem_ready = 1'b1;
                end
                if (mem_read)  rd_cyc++;
                if (mem_write) wr_cyc++;
            end else begin
                mem_ready = 1'b1;
            end
            if (reg_write) begin
                rw_cyc++;
                m2r = mem2reg;
            end
            step();
            cycles++;
        end while (!fetch_req && !halted && cycles < 50);
        chk("insn_completes", 32'(cycles < 50), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        int   cyc, rd, wr, rw;
        logic m2r;

        rst_n = 1'b0; mem_ready = 1'b1; ins = I_ADD; imm = '0; zero = 1'b0;
        repeat (2) step();
        chk("rst_fetch_req", 32'(fetch_req), 32'd0);
        chk("rst_ir_write",  32'(ir_write),  32'd0);
        chk("rst_reg_write", 32'(reg_write), 32'd0);
        chk("rst_mem_rw",    32'({mem_read, mem_write}), 32'd0);
        chk("rst_alu_op",    32'(alu_op), 32'd2);
        chk("rst_pc",        pc, 32'd128);
        chk("rst_count",     32'(insn_count), 32'd0);
        chk("rst_halt_ill",  32'({halted, illegal}), 32'd0);

        // add, cycle by cycle
        rst_n = 1'b1;
        #1;
        chk("add_c0_fetch_req", 32'(fetch_req), 32'd1);
        chk("add_c0_ir_write",  32'(ir_write),  32'd1);
        chk("add_c0_pc",        pc, 32'd128);
        step();
        chk("add_c1_fetch_req", 32'(fetch_req), 32'd0);
        chk("add_c1_ir_write",  32'(ir_write),  32'd0);
        step();
        chk("add_c2_alu_op",    32'(alu_op), 32'd2);
        chk("add_c2_reg_dst",   32'(reg_dst), 32'd1);
        chk("add_c2_alu_src",   32'(alu_src), 32'd0);
        chk("add_c2_reg_write", 32'(reg_write), 32'd0);
        step();
        chk("add_c3_reg_write", 32'(reg_write), 32'd1);
        chk("add_c3_mem2reg",   32'(mem2reg), 32'd0);
        step();
        chk("add_c4_reg_write", 32'(reg_write), 32'd0);
        chk("add_c4_fetch_req", 32'(fetch_req), 32'd1);
        chk("add_pc",           pc, 32'd132);
        chk("add_count",        32'(insn_count), 32'd1);

        run_insn(I_ADD, 0, cyc, rd, wr, rw, m2r);
        chk("add2_cycles", 32'(cyc), 32'd4);
        chk("add2_pc", pc, 32'd136);
        run_insn(I_ADD, 0, cyc, rd, wr, rw, m2r);
        chk("add3_pc", pc, 32'd140);
        chk("add3_count", 32'(insn_count), 32'd3);
        chk("add3_halted", 32'(halted), 32'd0);
        chk("budget_halted",  32'(b_halted), 32'd1);
        chk("budget_illegal", 32'(b_illegal), 32'd0);
        chk("budget_count",   32'(b_insn_count), 32'd3);
        chk("budget_pc",      b_pc, 32'd140);
        chk("budget_fetch_req", 32'(b_fetch_req), 32'd0);

        // beq imm=-2 at pc=140, taken then (after returning) not taken
        imm = 32'hFFFF_FFFE; zero = 1'b1;
        run_insn(I_BEQ, 0, cyc, rd, wr, rw, m2r);
        chk("beq_t_cycles", 32'(cyc), 32'd3);
        chk("beq_t_pc", pc, 32'd136);
        chk("beq_t_count", 32'(insn_count), 32'd4);
        zero = 1'b0;
        run_insn(I_ADD, 0, cyc, rd, wr, rw, m2r);
        chk("add4_pc", pc, 32'd140);
        run_insn(I_BEQ, 0, cyc, rd, wr, rw, m2r);
        chk("beq_nt_cycles", 32'(cyc), 32'd3);
        chk("beq_nt_pc", pc, 32'd144);
        chk("beq_nt_count", 32'(insn_count), 32'd6);

        // lw with 3 MEM wait cycles
        imm = 32'd4;
        run_insn(I_LW, 3, cyc, rd, wr, rw, m2r);
        chk("lw_cycles", 32'(cyc), 32'd8);
        chk("lw_mem_read_cycles", 32'(rd), 32'd4);
        chk("lw_reg_write_cycles", 32'(rw), 32'd1);
        chk("lw_mem2reg", 32'(m2r), 32'd1);
        chk("lw_pc", pc, 32'd148);
        chk("lw_count", 32'(insn_count), 32'd7);

        // jumps
        run_insn(I_J200, 0, cyc, rd, wr, rw, m2r);
        chk("j200_cycles", 32'(cyc), 32'd2);
        chk("j200_pc", pc, 32'd200);
        run_insn(I_J80, 0, cyc, rd, wr, rw, m2r);
        chk("j80_cycles", 32'(cyc), 32'd2);
        chk("j80_pc", pc, 32'h80);
        chk("j80_count", 32'(insn_count), 32'd9);

        // sw, zero-wait
        run_insn(I_SW, 0, cyc, rd, wr, rw, m2r);
        chk("sw_cycles", 32'(cyc), 32'd4);
        chk("sw_mem_write_cycles", 32'(wr), 32'd1);
        chk("sw_reg_write_cycles", 32'(rw), 32'd0);
        chk("sw_pc", pc, 32'd132);
        chk("sw_count", 32'(insn_count), 32'd10);

        // illegal opcode
        run_insn(I_BAD, 0, cyc, rd, wr, rw, m2r);
        chk("bad_cycles", 32'(cyc), 32'd2);
        chk("bad_halted", 32'(halted), 32'd1);
        chk("bad_illegal", 32'(illegal), 32'd1);
        repeat (3) step();
        chk("bad_pc_frozen", pc, 32'd132);
        chk("bad_count_frozen", 32'(insn_count), 32'd10);
        chk("bad_no_fetch", 32'(fetch_req), 32'd0);

        // reset mid-instruction aborts without retiring
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1; mem_ready = 1'b1; ins = I_ADD;
        #1;
        step();
        step();
        rst_n = 1'b0;
        step();
        chk("abort_pc", pc, 32'd128);
        chk("abort_count", 32'(insn_count), 32'd0);
        chk("abort_halt_ill", 32'({halted, illegal}), 32'd0);
        chk("abort_reg_write", 32'(reg_write), 32'd0);
        rst_n = 1'b1;
        #1;

        run_insn(I_SLT, 0, cyc, rd, wr, rw, m2r);
`ifdef Y_CTRL_SLT_EN
        chk("slt_cycles", 32'(cyc), 32'd4);
        chk("slt_halted", 32'(halted), 32'd0);
        chk("slt_pc", pc, 32'd132);
        chk("slt_count", 32'(insn_count), 32'd1);
`else
        chk("slt_cycles", 32'(cyc), 32'd2);
        chk("slt_halted", 32'(halted), 32'd1);
        chk("slt_illegal", 32'(illegal), 32'd1);
        chk("slt_pc", pc, 32'd128);
        chk("slt_count", 32'(insn_count), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
